// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory responder: FSM states,
// word/byte-enable widths and the access legality check.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_e;

  // Callers zero-extend the byte address so the range test sees every bit (no aliasing).
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth_words);
    logic [63:0] word_idx;
    word_idx = addr >> 2;
    return (addr[1:0] != 2'b00) || (word_idx >= 64'(depth_words));
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the datapath memory port (master)
// and the data memory responder (slave).
interface data_mem_responder_if #(
  parameter int ADDR_W = 32
);
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write, combinational read.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // Contents survive reset on purpose, like real memory.
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Stalling data memory responder: accepts one load/store, waits WAIT_CYCLES,
// accesses storage, then holds the response until the requester takes it.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              access_err;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign access_err = addr_err(64'(addr_q), DEPTH_WORDS);
  assign mem_we     = (state_q == ACCESS) && write_q && !access_err;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (be_q),
    .idx   (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        // Loads return the whole word; req_be only matters for stores.
        err_d   = access_err;
        rdata_d = (!access_err && !write_q) ? mem_rdata : '0;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states and
// one with none, driven from a shared stimulus selected by sel.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        tb_req_valid;
  logic        tb_req_write;
  logic [31:0] tb_req_addr;
  logic [31:0] tb_req_wdata;
  logic [3:0]  tb_req_be;
  logic        tb_rsp_ready;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(32)) bus2 ();
  data_mem_responder_if #(.ADDR_W(32)) bus0 ();

  assign bus2.req_valid = tb_req_valid & ~sel;
  assign bus2.req_write = tb_req_write;
  assign bus2.req_addr  = tb_req_addr;
  assign bus2.req_wdata = tb_req_wdata;
  assign bus2.req_be    = tb_req_be;
  assign bus2.rsp_ready = tb_rsp_ready;
  assign bus0.req_valid = tb_req_valid & sel;
  assign bus0.req_write = tb_req_write;
  assign bus0.req_addr  = tb_req_addr;
  assign bus0.req_wdata = tb_req_wdata;
  assign bus0.req_be    = tb_req_be;
  assign bus0.rsp_ready = tb_rsp_ready;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;
  assign cur_req_ready = sel ? bus0.req_ready : bus2.req_ready;
  assign cur_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
  assign cur_rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;
  assign cur_rsp_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;

  typedef struct {
    logic        sel;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int N_VEC = 20;
  vec_t vecs [N_VEC];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    n_fails++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Issues one request and returns at the first negedge where rsp_valid is seen.
  task automatic applyStimulus(input logic s, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] b,
                               output logic [31:0] rd, output logic er, output int lat);
    int guard;
    sel   = s;
    guard = 0;
    while (!cur_req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 50) reportTimeout("req_ready_wait");
    tb_req_valid = 1'b1;
    tb_req_write = w;
    tb_req_addr  = a;
    tb_req_wdata = wd;
    tb_req_be    = b;
    @(posedge clk);
    @(negedge clk);
    tb_req_valid = 1'b0;
    tb_req_write = ~w;
    tb_req_addr  = ~a;
    tb_req_wdata = ~wd;
    tb_req_be    = ~b;
    lat = 1;
    while (!cur_rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!cur_rsp_valid) reportTimeout("rsp_valid_wait");
    rd = cur_rsp_rdata;
    er = cur_rsp_err;
  endtask

  task automatic finishResponse();
    tb_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_rsp_ready = 1'b0;
    checkOutput("post_rsp_req_ready", {31'd0, cur_req_ready}, 32'd1);
    checkOutput("post_rsp_valid",     {31'd0, cur_rsp_valid}, 32'd0);
    checkOutput("post_rsp_rdata",     cur_rsp_rdata,          32'd0);
    checkOutput("post_rsp_err",       {31'd0, cur_rsp_err},   32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          responses;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    32'h0,        1'b0, 4};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 4};
    vecs[2]  = '{1'b0, 1'b1, 32'h10,       32'h11223344, 4'b0101, 32'h0,        1'b0, 4};
    vecs[3]  = '{1'b0, 1'b0, 32'h10,       32'h0,        4'hF,    32'hDE22BE44, 1'b0, 4};
    vecs[4]  = '{1'b0, 1'b1, 32'h10,       32'hFFFFFFFF, 4'h0,    32'h0,        1'b0, 4};
    vecs[5]  = '{1'b0, 1'b0, 32'h10,       32'h0,        4'h0,    32'hDE22BE44, 1'b0, 4};
    vecs[6]  = '{1'b0, 1'b1, 32'h0,        32'hCAFEF00D, 4'hF,    32'h0,        1'b0, 4};
    vecs[7]  = '{1'b0, 1'b0, 32'h12,       32'h0,        4'hF,    32'h0,        1'b1, 4};
    vecs[8]  = '{1'b0, 1'b1, 32'h400,      32'h12345678, 4'hF,    32'h0,        1'b1, 4};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        4'hF,    32'hCAFEF00D, 1'b0, 4};
    vecs[10] = '{1'b0, 1'b1, 32'h3FC,      32'hA5A5A5A5, 4'hF,    32'h0,        1'b0, 4};
    vecs[11] = '{1'b0, 1'b0, 32'h3FC,      32'h0,        4'hF,    32'hA5A5A5A5, 1'b0, 4};
    vecs[12] = '{1'b0, 1'b0, 32'h400,      32'h0,        4'hF,    32'h0,        1'b1, 4};
    vecs[13] = '{1'b0, 1'b1, 32'h20,       32'h01020304, 4'hF,    32'h0,        1'b0, 4};
    vecs[14] = '{1'b0, 1'b0, 32'h20,       32'h0,        4'hF,    32'h01020304, 1'b0, 4};
    vecs[15] = '{1'b0, 1'b1, 32'h11,       32'h99999999, 4'hF,    32'h0,        1'b1, 4};
    vecs[16] = '{1'b0, 1'b0, 32'h10,       32'h0,        4'hF,    32'hDE22BE44, 1'b0, 4};
    vecs[17] = '{1'b1, 1'b1, 32'h8,        32'h0BADCAFE, 4'hF,    32'h0,        1'b0, 2};
    vecs[18] = '{1'b1, 1'b0, 32'h8,        32'h0,        4'hF,    32'h0BADCAFE, 1'b0, 2};
    vecs[19] = '{1'b1, 1'b0, 32'h10000000, 32'h0,        4'hF,    32'h0,        1'b1, 2};

    reset        = 1'b0;
    sel          = 1'b0;
    tb_req_valid = 1'b0;
    tb_req_write = 1'b0;
    tb_req_addr  = '0;
    tb_req_wdata = '0;
    tb_req_be    = '0;
    tb_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset_req_ready_w2", {31'd0, bus2.req_ready}, 32'd1);
    checkOutput("reset_rsp_valid_w2", {31'd0, bus2.rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata_w2", bus2.rsp_rdata,          32'd0);
    checkOutput("reset_rsp_err_w2",   {31'd0, bus2.rsp_err},   32'd0);
    checkOutput("reset_req_ready_w0", {31'd0, bus0.req_ready}, 32'd1);
    checkOutput("reset_rsp_valid_w0", {31'd0, bus0.rsp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N_VEC; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      checkOutput($sformatf("vec%0d_rdata", i), rd,             vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i),   {31'd0, er},    {31'd0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_lat", i),   32'(lat),       32'(vecs[i].exp_lat));
      finishResponse();
    end

    // Backpressure: response must hold steady while rsp_ready stays low.
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    checkOutput("bp_lat", 32'(lat), 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", {31'd0, cur_rsp_valid}, 32'd1);
      checkOutput("bp_rsp_rdata", cur_rsp_rdata,          32'hDE22BE44);
      checkOutput("bp_rsp_err",   {31'd0, cur_rsp_err},   32'd0);
      checkOutput("bp_req_ready", {31'd0, cur_req_ready}, 32'd0);
    end
    finishResponse();

    // Back-to-back loads with req_valid held high on the zero-wait instance:
    // IDLE -> ACCESS -> RESP repeats, one response per accepted request.
    sel          = 1'b1;
    tb_req_valid = 1'b1;
    tb_req_write = 1'b0;
    tb_req_addr  = 32'h8;
    tb_req_be    = 4'hF;
    tb_rsp_ready = 1'b1;
    responses    = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput("b2b_req_ready", {31'd0, cur_req_ready}, {31'd0, (k % 3) == 0});
      checkOutput("b2b_rsp_valid", {31'd0, cur_rsp_valid}, {31'd0, (k % 3) == 2});
      if (cur_rsp_valid) begin
        responses++;
        checkOutput("b2b_rsp_rdata", cur_rsp_rdata, 32'h0BADCAFE);
      end
    end
    tb_req_valid = 1'b0;
    tb_rsp_ready = 1'b0;
    checkOutput("b2b_responses", 32'(responses), 32'd4);

    // Reset one cycle into WAIT of a store: the store must never land.
    @(negedge clk);
    sel          = 1'b0;
    tb_req_valid = 1'b1;
    tb_req_write = 1'b1;
    tb_req_addr  = 32'h20;
    tb_req_wdata = 32'hFFFF0000;
    tb_req_be    = 4'hF;
    @(posedge clk);
    @(negedge clk);
    tb_req_valid = 1'b0;
    reset        = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrst_req_ready", {31'd0, cur_req_ready}, 32'd1);
    checkOutput("midrst_rsp_valid", {31'd0, cur_rsp_valid}, 32'd0);
    checkOutput("midrst_rsp_rdata", cur_rsp_rdata,          32'd0);
    checkOutput("midrst_rsp_err",   {31'd0, cur_rsp_err},   32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_rsp", {31'd0, cur_rsp_valid}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    checkOutput("midrst_load_rdata", rd,          32'h01020304);
    checkOutput("midrst_load_err",   {31'd0, er}, 32'd0);
    finishResponse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's data accesses.
- Accepts one load/store request at a time over a valid/ready handshake.
- Models a configurable number of wait states, then returns read data or a write acknowledgement over a response handshake.
- Sits between the datapath's memory request port and word-organised data storage; replaces the zero-latency data memory so the core can be exercised against a stalling memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, at least 4.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and the storage access; range 0..15.
- ADDR_W, 32, request address width in bits (byte address).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset asserted)
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data
- req_be  input  4  byte enables for stores; bit i covers wdata[8i+7:8i]
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Storage contents are NOT cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T: latch write, addr, wdata, be.
  - Load counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; when it reaches 1, the next state is ACCESS.
- ACCESS (one cycle):
  - req_ready=0.
  - Error check: error if addr[1:0]!=0 or addr[ADDR_W-1:2]>=DEPTH_WORDS.
  - No error, store: write each enabled byte of word addr[ADDR_W-1:2]; rsp_rdata=0.
  - No error, load: rsp_rdata=full stored word (req_be ignored).
  - Error: storage untouched, rsp_rdata=0, rsp_err=1.
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready: next state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency:
  - rsp_valid first high in cycle T+2+WAIT_CYCLES.
  - The store is committed at edge T+1+WAIT_CYCLES.
  - req_ready returns high the cycle after the response handshake; no request overlap.
- Store with req_be=4'b0000: no storage change, rsp_err=0.
- Signal changes on req_* while req_ready=0 are ignored.
- Reset mid-operation:
  - In WAIT, the pending store is discarded and storage is unchanged.
  - In RESP, the store is already committed and the response is dropped.
- Out-of-range check uses full address bits; no wrap-around aliasing.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, WAIT, ACCESS, RESP)
  - WORD_W=32, BE_W=4
  - error-check helper function (alignment + range)
- Sub-module dmem_array holds the storage:
  - DEPTH_WORDS x 32, synchronous byte-enabled write, combinational read.
  - Instantiated once; the FSM drives its word index, write enable and byte enables.

Test Plan:
- WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF; accept at T -> rsp_valid at T+4, rsp_err=0. Then load 0x10 -> rsp_rdata=0xDEADBEEF.
- Store 0x10 be 4'b0101 wdata 0x11223344 over 0xDEADBEEF -> load 0x10 returns 0xDE22BE44. Store with be=0 -> word unchanged, rsp_err=0.
- Misaligned load 0x12 -> rsp_err=1, rsp_rdata=0. Store to 0x400 (word 256, DEPTH_WORDS=256) -> rsp_err=1, word 0 unchanged (no aliasing).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0 throughout; on rsp_ready=1, req_ready=1 next cycle.
- WAIT_CYCLES=0: load accepted at T -> rsp_valid at T+2. Back-to-back requests with req_valid held high -> each accepted only when req_ready=1, one response per request.
- Assert reset=0 one cycle into WAIT of a store to 0x20 -> outputs return to reset values, req_ready=1; subsequent load of 0x20 returns the prior contents.
